uart_tx: RTL and testbench

- Serial debug transmitter for the discrete-cell CPU. Drives the board's debug UART line and mirrors activity on a status LED output.
- The CPU core writes bytes through a valid/ready port. A small FIFO buffers them, and a bit-timing FSM serialises each byte as 8N1 (one start bit, eight data bits, one stop bit).
- It is the transmit-side counterpart of the board's debug receive path. It is synthesised onto the discrete cell set, so it uses no memories; FIFO storage is flip-flops only.

---
 rtl/uart_tx_if.sv | 17 +
 rtl/uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_if
// Purpose  : Byte write port (valid/ready) between the CPU core and uart_tx.
// Revision : 1.0
// ============================================================================

interface uart_tx_if;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 debug UART transmitter with flip-flop FIFO and activity LED.
// Revision : 1.0
// ============================================================================

module uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  wire                          clk,
  input  wire                          rst_n,
  uart_tx_if.slave                     wr,
  output logic                         txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         led
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_div_w = $clog2(CLK_DIV);

  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("uart_tx: CLK_DIV must be in 2..255");
  end

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two in 2..8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  state_t             r_state;
  logic [c_div_w-1:0] r_div;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_txd;
  logic               r_busy;
  logic               r_led;

  logic               w_push;
  logic               w_pop;
  logic               w_nonempty;
  logic               w_div_end;
  logic               w_frame_done;
  logic               w_goes_idle;
  logic               w_busy_nxt;
  logic [c_cnt_w-1:0] w_count_nxt;

  assign wr.wr_ready  = (r_count < c_depth);
  assign w_push       = wr.wr_valid && wr.wr_ready;
  assign w_nonempty   = (r_count != '0);
  assign w_div_end    = (r_div == c_div_last);

  // The FSM takes a new byte either from IDLE or at the end of a stop bit.
  assign w_frame_done = (r_state == S_IDLE) || ((r_state == S_STOP) && w_div_end);
  assign w_pop        = w_nonempty && w_frame_done;
  assign w_goes_idle  = !w_nonempty && w_frame_done;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_w'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_w'(1);
    end
  end

  // BUSY is built from next-cycle state so it drops exactly as the stop bit ends.
  assign w_busy_nxt = !w_goes_idle || (w_count_nxt != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          r_bit <= '0;
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_txd   <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_div <= r_div + c_div_w'(1);
          end
        end
        S_DATA: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_bit == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_txd   <= r_shift[1];
            end
          end else begin
            r_div <= r_div + c_div_w'(1);
          end
        end
        S_STOP: begin
          if (w_div_end) begin
            r_div <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_div <= r_div + c_div_w'(1);
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_led  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_led  <= r_busy;
    end
  end

  assign txd        = r_txd;
  assign busy       = r_busy;
  assign led        = r_led;
  assign fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Directed self-checking bench for uart_tx at CLK_DIV=4 and CLK_DIV=2.
// Revision : 1.0
// ============================================================================

module tb_uart_tx;

  logic       clk;
  logic       rst_n;
  logic       txd4, busy4, led4;
  logic       txd2, busy2, led2;
  logic [2:0] cnt4, cnt2;

  int n_checks;
  int n_fail;

  uart_tx_if wr4 ();
  uart_tx_if wr2 ();

  uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr4),
    .txd        (txd4),
    .busy       (busy4),
    .fifo_count (cnt4),
    .led        (led4)
  );

  uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr         (wr2),
    .txd        (txd2),
    .busy       (busy2),
    .fifo_count (cnt2),
    .led        (led2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Checks the line once per cycle across n back-to-back frames; byte f is bytes[8f+:8].
  task automatic expect_frames(input int sel, input int div, input logic [63:0] bytes,
                               input int n, input string tag);
    logic       lvl;
    logic [7:0] b;
    for (int f = 0; f < n; f++) begin
      b = bytes[8*f +: 8];
      for (int j = 0; j < 10; j++) begin
        lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
        for (int c = 0; c < div; c++) begin
          check(tag, 32'((sel == 2) ? txd2 : txd4), 32'(lvl));
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    wr4.wr_valid = 1'b1;
    wr4.wr_data  = 8'hAA;
    wr2.wr_valid = 1'b1;
    wr2.wr_data  = 8'hAA;

    // Reset held with a pending write: nothing may be accepted.
    repeat (3) @(negedge clk);
    check("rst_txd",   32'(txd4),         32'd1);
    check("rst_ready", 32'(wr4.wr_ready), 32'd1);
    check("rst_count", 32'(cnt4),         32'd0);
    check("rst_busy",  32'(busy4),        32'd0);
    check("rst_led",   32'(led4),         32'd0);
    check("rst_txd2",  32'(txd2),         32'd1);
    wr4.wr_valid = 1'b0;
    wr2.wr_valid = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check("post_rst_count", 32'(cnt4), 32'd0);
    check("post_rst_busy",  32'(busy4), 32'd0);

    // Single byte 0xA5 at CLK_DIV=4.
    wr4.wr_valid = 1'b1;
    wr4.wr_data  = 8'hA5;
    @(negedge clk);
    wr4.wr_valid = 1'b0;
    check("a5_count",    32'(cnt4),  32'd1);
    check("a5_idle_txd", 32'(txd4),  32'd1);
    check("a5_busy",     32'(busy4), 32'd1);
    @(negedge clk);
    expect_frames(4, 4, 64'h00000000_000000A5, 1, "a5_line");
    check("a5_busy_end", 32'(busy4), 32'd0);
    check("a5_led_lag",  32'(led4),  32'd1);
    check("a5_count_end", 32'(cnt4), 32'd0);
    @(negedge clk);
    check("a5_led_end",  32'(led4),  32'd0);

    // Back-to-back 0x00 then 0xFF: 80 cycles with no idle gap.
    wr4.wr_valid = 1'b1;
    wr4.wr_data  = 8'h00;
    @(negedge clk);
    wr4.wr_data  = 8'hFF;
    @(negedge clk);
    wr4.wr_valid = 1'b0;
    expect_frames(4, 4, 64'h00000000_0000FF00, 2, "b2b_line");
    check("b2b_busy_end", 32'(busy4), 32'd0);

    // Six continuous writes against a depth-4 FIFO.
    wr4.wr_valid = 1'b1;
    wr4.wr_data  = 8'h11;
    @(negedge clk);
    wr4.wr_data  = 8'h22;
    fork
      begin
        @(negedge clk);
        expect_frames(4, 4, 64'h00006655_44332211, 6, "full_line");
      end
      begin
        @(negedge clk);
        wr4.wr_data = 8'h33;
        @(negedge clk);
        wr4.wr_data = 8'h44;
        @(negedge clk);
        wr4.wr_data = 8'h55;
        @(negedge clk);
        check("full_count",   32'(cnt4),         32'd4);
        check("full_ready",   32'(wr4.wr_ready), 32'd0);
        wr4.wr_data = 8'h66;
        repeat (36) @(negedge clk);
        check("full_hold_count", 32'(cnt4),         32'd4);
        check("full_hold_ready", 32'(wr4.wr_ready), 32'd0);
        @(negedge clk);
        check("full_freed_ready", 32'(wr4.wr_ready), 32'd1);
        check("full_freed_count", 32'(cnt4),         32'd3);
        @(negedge clk);
        wr4.wr_valid = 1'b0;
        check("full_refill_count", 32'(cnt4), 32'd4);
      end
    join
    check("full_busy_end",  32'(busy4), 32'd0);
    check("full_count_end", 32'(cnt4),  32'd0);

    // Reset during data bit 3 of 0x3C with one more byte queued.
    wr4.wr_valid = 1'b1;
    wr4.wr_data  = 8'h3C;
    @(negedge clk);
    wr4.wr_data  = 8'h99;
    @(negedge clk);
    wr4.wr_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_pre_count", 32'(cnt4), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txd",   32'(txd4),         32'd1);
    check("mid_rst_count", 32'(cnt4),         32'd0);
    check("mid_rst_busy",  32'(busy4),        32'd0);
    check("mid_rst_ready", 32'(wr4.wr_ready), 32'd1);
    @(negedge clk);
    check("mid_hold_txd",  32'(txd4), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    wr4.wr_valid = 1'b1;
    wr4.wr_data  = 8'h55;
    @(negedge clk);
    wr4.wr_valid = 1'b0;
    check("fresh_count", 32'(cnt4), 32'd1);
    @(negedge clk);
    expect_frames(4, 4, 64'h00000000_00000055, 1, "fresh_line");
    check("fresh_busy_end", 32'(busy4), 32'd0);

    // CLK_DIV=2 with 0x81; LED trails BUSY by one cycle.
    wr2.wr_valid = 1'b1;
    wr2.wr_data  = 8'h81;
    @(negedge clk);
    wr2.wr_valid = 1'b0;
    check("div2_busy_rise", 32'(busy2), 32'd1);
    check("div2_led_lag",   32'(led2),  32'd0);
    @(negedge clk);
    check("div2_led_rise",  32'(led2),  32'd1);
    expect_frames(2, 2, 64'h00000000_00000081, 1, "div2_line");
    check("div2_busy_end",  32'(busy2), 32'd0);
    check("div2_led_hold",  32'(led2),  32'd1);
    @(negedge clk);
    check("div2_led_end",   32'(led2),  32'd0);
    check("div2_txd_idle",  32'(txd2),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
